serializer_param: RTL and testbench
===================================

Name: serializer_param

Overview:
- Parametrised parallel-to-serial converter for the UART transmit path; successor to the fixed 8-bit serializer.
- Sits between the TX control FSM and the TX output mux.
- Accepts a DATA_WIDTH word through a valid/ready handshake and presents it one bit at a time, LSB- or MSB-first.
- Advances one bit per serial_enable cycle, so it stalls cleanly. Supports back-to-back words with no idle cycle.

Parameters:
DATA_WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 0, 0 = LSB transmitted first, 1 = MSB transmitted first.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  synchronous reset, active-high.
P_DATA  input  DATA_WIDTH  parallel word; sampled only on an accepted load.
Data_valid  input  1  load request.
ser_ready  output  1  block can accept a word this cycle.
serial_enable  input  1  consume current bit this cycle.
serial_Data  output  1  current serial bit.
serial_busy  output  1  a word is loaded and not yet fully consumed.
serial_done  output  1  single-cycle pulse: last bit consumed this cycle.

Behaviour:
- Reset:
  - RST=1 at a rising CLK edge gives state IDLE, shift_reg=0 and bit_cnt=0.
  - Resulting outputs: serial_Data=0, serial_busy=0, serial_done=0, ser_ready=1.
  - Reset has priority over all other inputs, including mid-word; the partial word is discarded.
- Internal state:
  - shift_reg[DATA_WIDTH-1:0].
  - bit_cnt, width $clog2(DATA_WIDTH).
  - FSM with two states: IDLE and SHIFT.
- serial_Data:
  - SHIFT: shift_reg[0] when MSB_FIRST=0, shift_reg[DATA_WIDTH-1] when MSB_FIRST=1.
  - IDLE: 0.
- serial_busy = (state==SHIFT).
- serial_done (combinational) = SHIFT && serial_enable && bit_cnt==DATA_WIDTH-1.
- ser_ready (combinational) = IDLE || serial_done.
- Load = Data_valid && ser_ready:
  - shift_reg <= P_DATA, bit_cnt <= 0, state <= SHIFT.
  - First bit appears on serial_Data the cycle after the load edge. Latency is 1 cycle.
- SHIFT with serial_enable=1 and bit_cnt < DATA_WIDTH-1:
  - Shift toward the output end, zero-filled: right shift for LSB-first, left shift for MSB-first.
  - bit_cnt <= bit_cnt+1.
- SHIFT with serial_enable=1 and bit_cnt == DATA_WIDTH-1:
  - serial_done=1 that cycle.
  - If Data_valid=1 the same cycle: load the new word and stay in SHIFT (back-to-back, no gap).
  - Otherwise: state <= IDLE, shift_reg <= 0, bit_cnt <= 0.
- SHIFT with serial_enable=0: hold all state. serial_Data is stable for any number of stall cycles.
- Data_valid while ser_ready=0: ignored, with no side effect. The upstream block must hold the word until accepted.
- serial_enable in IDLE: ignored; no done pulse.
- A full word consumes exactly DATA_WIDTH enable cycles; serial_done fires once per word.

Optional Feature:
Macro SERIALIZER_PARITY_EN.
- Defined:
  - Adds parameter PAR_ODD (default 0).
  - Adds output par_bit (1 bit).
  - par_bit is registered on every load as ^P_DATA (even parity), or ~^P_DATA when PAR_ODD=1.
  - par_bit holds until the next load; reset value 0.
  - par_bit is stable from the first bit through serial_done, for use by the TX mux.
- Not defined: no par_bit port and no parity logic; all other behaviour is identical.

Test Plan:
- Basic LSB-first: DATA_WIDTH=8, MSB_FIRST=0, load 0xC5, serial_enable held 1.
  - Required: serial_Data = 1,0,1,0,0,0,1,1 on 8 consecutive cycles.
  - serial_done high only on the 8th cycle; ser_ready=1 and serial_busy=0 the cycle after.
- MSB-first: MSB_FIRST=1, load 0xC5, enable held 1.
  - Required: serial_Data = 1,1,0,0,0,1,0,1; done on the 8th bit.
- Stall: LSB-first, load 0xC5, enable pattern 1,0,0,1,1,0,1,1,1,1,1.
  - Required: each bit held through the 0 cycles; exactly 8 enabled cycles to done; done pulses once.
- Back-to-back and width: DATA_WIDTH=12, load 0xABC; assert Data_valid with 0x123 in the done cycle.
  - Required: next cycle serial_Data=1 (bit 0 of 0x123) with serial_busy held 1 and no idle gap.
  - Data_valid with 0x555 during mid-word is ignored.
- Reset mid-word: RST=1 after 3 bits of 0xC5.
  - Required: next edge gives serial_Data=0, busy=0, ready=1.
  - A subsequent load of 0x0F serialises as 1,1,1,1,0,0,0,0.
- Parity (SERIALIZER_PARITY_EN defined):
  - Load 0xC5: par_bit=0 when PAR_ODD=0, 1 when PAR_ODD=1.
  - Load 0x07: par_bit=1 when PAR_ODD=0.
  - par_bit is held until the next load.

Source files
------------

// File: rtl/serializer_param.sv
// -----------------------------------------------------------------------------
// serializer_param
// Parameterised parallel-to-serial converter for the UART transmit path.
// A DATA_WIDTH word is accepted through a valid/ready handshake and emitted
// one bit per serial_enable cycle, LSB- or MSB-first. The block stalls cleanly
// when serial_enable is low and accepts a new word in the cycle the last bit
// is consumed, so back-to-back words have no idle gap.
//
// Optional feature macro: SERIALIZER_PARITY_EN
//   When defined, adds parameter PAR_ODD and output par_bit. par_bit is the
//   parity of the last loaded word (even, or odd when PAR_ODD=1). It is
//   captured on every load and held until the next load.
//
// Parameters:
//   DATA_WIDTH  word width in bits (2..32)
//   MSB_FIRST   0 = LSB transmitted first, 1 = MSB transmitted first
//   PAR_ODD     (SERIALIZER_PARITY_EN only) 0 = even parity, 1 = odd parity
//
// Ports:
//   CLK            clock, rising edge
//   RST            synchronous reset, active-high
//   P_DATA         parallel word, sampled only on an accepted load
//   Data_valid     load request
//   ser_ready      block can accept a word this cycle
//   serial_enable  consume current bit this cycle
//   serial_Data    current serial bit (0 when idle)
//   serial_busy    a word is loaded and not yet fully consumed
//   serial_done    single-cycle pulse: last bit consumed this cycle
//   par_bit        (SERIALIZER_PARITY_EN only) parity of the loaded word
// -----------------------------------------------------------------------------
module serializer_param #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
`ifdef SERIALIZER_PARITY_EN
  ,
  parameter bit PAR_ODD    = 1'b0
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  output logic                  ser_ready,
  input  logic                  serial_enable,
  output logic                  serial_Data,
  output logic                  serial_busy,
  output logic                  serial_done
`ifdef SERIALIZER_PARITY_EN
  ,
  output logic                  par_bit
`endif
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic [DATA_WIDTH-1:0]   shift_nxt_s;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [CNT_W-1:0]        bit_cnt_nxt_s;
  logic                    done_s;
  logic                    ready_s;
  logic                    load_s;

  // Move the next bit to the output end, zero-filling the vacated position.
  function automatic logic [DATA_WIDTH-1:0] shift_step(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {v[DATA_WIDTH-2:0], 1'b0};
    end else begin
      r = {1'b0, v[DATA_WIDTH-1:1]};
    end
    return r;
  endfunction

  // Handshake terms: a word completes when its last bit is consumed, and the
  // block is ready either when idle or in that completing cycle.
  always_comb begin
    done_s  = 1'b0;
    ready_s = 1'b0;
    load_s  = 1'b0;
    if (state_r == SHIFT) begin
      done_s = serial_enable && (bit_cnt_r == LAST_CNT);
    end else begin
      done_s = 1'b0;
    end
    ready_s = (state_r == IDLE) || done_s;
    load_s  = Data_valid && ready_s;
  end

  // Next-state, shift register and bit counter update.
  always_comb begin
    state_nxt_s   = state_r;
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    if (load_s) begin
      // Covers both a load from IDLE and a back-to-back load on the done cycle.
      state_nxt_s   = SHIFT;
      shift_nxt_s   = P_DATA;
      bit_cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s   = IDLE;
          shift_nxt_s   = shift_r;
          bit_cnt_nxt_s = bit_cnt_r;
        end
        SHIFT: begin
          if (done_s) begin
            state_nxt_s   = IDLE;
            shift_nxt_s   = {DATA_WIDTH{1'b0}};
            bit_cnt_nxt_s = {CNT_W{1'b0}};
          end else if (serial_enable) begin
            shift_nxt_s   = shift_step(shift_r);
            bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
          end else begin
            // Stall: hold everything so serial_Data stays stable.
            shift_nxt_s   = shift_r;
            bit_cnt_nxt_s = bit_cnt_r;
          end
        end
        default: begin
          state_nxt_s   = IDLE;
          shift_nxt_s   = {DATA_WIDTH{1'b0}};
          bit_cnt_nxt_s = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, shift register and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      shift_r   <= {DATA_WIDTH{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      shift_r   <= shift_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
    end
  end

  // Output decode: the serial bit is forced low while idle.
  always_comb begin
    serial_Data = 1'b0;
    if (state_r == SHIFT) begin
      if (MSB_FIRST) begin
        serial_Data = shift_r[DATA_WIDTH-1];
      end else begin
        serial_Data = shift_r[0];
      end
    end else begin
      serial_Data = 1'b0;
    end
  end

  assign serial_busy = (state_r == SHIFT);
  assign serial_done = done_s;
  assign ser_ready   = ready_s;

`ifdef SERIALIZER_PARITY_EN
  logic par_r;

  // Parity of a word, inverted for odd parity.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  // Capture parity on each accepted load; it then holds for the whole word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_r <= 1'b0;
    end else if (load_s) begin
      par_r <= calc_parity(P_DATA);
    end else begin
      par_r <= par_r;
    end
  end

  assign par_bit = par_r;
`endif

endmodule

// File: tb/tb_serializer_param.sv
// -----------------------------------------------------------------------------
// tb_serializer_param
// Directed self-checking bench for serializer_param. Three instances:
//   u_lsb : DATA_WIDTH=8,  LSB-first (even parity when parity is built in)
//   u_msb : DATA_WIDTH=8,  MSB-first, shares stimulus with u_lsb (odd parity)
//   u_w12 : DATA_WIDTH=12, LSB-first, own stimulus for back-to-back tests
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_serializer_param;

  logic        CLK = 1'b0;
  logic        RST;

  logic [7:0]  pd8;
  logic        dv8, en8;
  logic        rdy_l, sd_l, busy_l, done_l;
  logic        rdy_m, sd_m, busy_m, done_m;

  logic [11:0] pd12;
  logic        dv12, en12;
  logic        rdy_w, sd_w, busy_w, done_w;

`ifdef SERIALIZER_PARITY_EN
  logic        par_l, par_m, par_w;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 CLK = ~CLK;

  serializer_param #(
    .DATA_WIDTH(8), .MSB_FIRST(1'b0)
`ifdef SERIALIZER_PARITY_EN
    , .PAR_ODD(1'b0)
`endif
  ) u_lsb (
    .CLK(CLK), .RST(RST), .P_DATA(pd8), .Data_valid(dv8), .ser_ready(rdy_l),
    .serial_enable(en8), .serial_Data(sd_l), .serial_busy(busy_l), .serial_done(done_l)
`ifdef SERIALIZER_PARITY_EN
    , .par_bit(par_l)
`endif
  );

  serializer_param #(
    .DATA_WIDTH(8), .MSB_FIRST(1'b1)
`ifdef SERIALIZER_PARITY_EN
    , .PAR_ODD(1'b1)
`endif
  ) u_msb (
    .CLK(CLK), .RST(RST), .P_DATA(pd8), .Data_valid(dv8), .ser_ready(rdy_m),
    .serial_enable(en8), .serial_Data(sd_m), .serial_busy(busy_m), .serial_done(done_m)
`ifdef SERIALIZER_PARITY_EN
    , .par_bit(par_m)
`endif
  );

  serializer_param #(
    .DATA_WIDTH(12), .MSB_FIRST(1'b0)
`ifdef SERIALIZER_PARITY_EN
    , .PAR_ODD(1'b0)
`endif
  ) u_w12 (
    .CLK(CLK), .RST(RST), .P_DATA(pd12), .Data_valid(dv12), .ser_ready(rdy_w),
    .serial_enable(en12), .serial_Data(sd_w), .serial_busy(busy_w), .serial_done(done_w)
`ifdef SERIALIZER_PARITY_EN
    , .par_bit(par_w)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: through the rising edge to the next falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    logic [7:0]  word_c5;
    logic [7:0]  word_0f;
    logic [7:0]  word_07;
    logic [11:0] word_abc;
    logic [11:0] word_123;
    logic [10:0] stall_pat;
    int          k;
    int          done_cnt;

    word_c5   = 8'hC5;
    word_0f   = 8'h0F;
    word_07   = 8'h07;
    word_abc  = 12'hABC;
    word_123  = 12'h123;
    stall_pat = 11'b11111011001;   // bit j = enable in stall cycle j

    RST = 1'b1; pd8 = 8'h00; dv8 = 1'b0; en8 = 1'b0;
    pd12 = 12'h000; dv12 = 1'b0; en12 = 1'b0;
    tick();

    // ---------------- reset state ----------------
    RST = 1'b0;
    #1;
    check("rst_sd",    {31'd0, sd_l},   32'd0);
    check("rst_busy",  {31'd0, busy_l}, 32'd0);
    check("rst_done",  {31'd0, done_l}, 32'd0);
    check("rst_ready", {31'd0, rdy_l},  32'd1);
    check("rst_ready12", {31'd0, rdy_w}, 32'd1);
`ifdef SERIALIZER_PARITY_EN
    check("rst_par", {31'd0, par_l}, 32'd0);
`endif

    // ---------------- basic LSB / MSB with C5, enable held ----------------
    tick();
    pd8 = 8'hC5; dv8 = 1'b1; en8 = 1'b0;
    #1;
    check("load_ready", {31'd0, rdy_l}, 32'd1);
    tick();
    dv8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en8 = 1'b1;
      #1;
      check("lsb_bit",  {31'd0, sd_l},   {31'd0, word_c5[i]});
      check("msb_bit",  {31'd0, sd_m},   {31'd0, word_c5[7-i]});
      check("lsb_done", {31'd0, done_l}, (i == 7) ? 32'd1 : 32'd0);
      check("msb_done", {31'd0, done_m}, (i == 7) ? 32'd1 : 32'd0);
      check("lsb_busy", {31'd0, busy_l}, 32'd1);
`ifdef SERIALIZER_PARITY_EN
      check("par_even_c5", {31'd0, par_l}, 32'd0);
      check("par_odd_c5",  {31'd0, par_m}, 32'd1);
`endif
      tick();
    end
    en8 = 1'b0;
    #1;
    check("post_ready", {31'd0, rdy_l},  32'd1);
    check("post_busy",  {31'd0, busy_l}, 32'd0);
    check("post_sd",    {31'd0, sd_l},   32'd0);
    check("post_done",  {31'd0, done_l}, 32'd0);

    // ---------------- enable while idle is ignored ----------------
    tick();
    en8 = 1'b1;
    #1;
    check("idle_en_done", {31'd0, done_l}, 32'd0);
    tick();
    en8 = 1'b0;
    #1;
    check("idle_en_busy", {31'd0, busy_l}, 32'd0);

    // ---------------- stall pattern ----------------
    tick();
    pd8 = 8'hC5; dv8 = 1'b1;
    tick();
    dv8 = 1'b0;
    k = 0;
    done_cnt = 0;
    for (int j = 0; j < 11; j++) begin
      en8 = stall_pat[j];
      #1;
      check("stall_bit",  {31'd0, sd_l},   {31'd0, word_c5[k]});
      check("stall_mbit", {31'd0, sd_m},   {31'd0, word_c5[7-k]});
      check("stall_done", {31'd0, done_l}, (en8 && k == 7) ? 32'd1 : 32'd0);
      check("stall_busy", {31'd0, busy_l}, 32'd1);
      if (done_l) done_cnt++;
      tick();
      if (stall_pat[j]) k++;
    end
    en8 = 1'b0;
    #1;
    check("stall_done_cnt", done_cnt, 32'd1);
    check("stall_end_busy", {31'd0, busy_l}, 32'd0);

    // ---------------- reset mid-word ----------------
    tick();
    pd8 = 8'hC5; dv8 = 1'b1;
    tick();
    dv8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en8 = 1'b1;
      tick();
    end
    en8 = 1'b0; RST = 1'b1;
    #1;
    check("pre_rst_bit", {31'd0, sd_l}, {31'd0, word_c5[3]});
    tick();
    RST = 1'b0;
    #1;
    check("midrst_sd",    {31'd0, sd_l},   32'd0);
    check("midrst_busy",  {31'd0, busy_l}, 32'd0);
    check("midrst_ready", {31'd0, rdy_l},  32'd1);
`ifdef SERIALIZER_PARITY_EN
    check("midrst_par",   {31'd0, par_l},  32'd0);
`endif
    pd8 = 8'h0F; dv8 = 1'b1;
    tick();
    dv8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en8 = 1'b1;
      #1;
      check("rst_0f_bit",  {31'd0, sd_l},   {31'd0, word_0f[i]});
      check("rst_0f_done", {31'd0, done_l}, (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    en8 = 1'b0;

`ifdef SERIALIZER_PARITY_EN
    // ---------------- parity of 0x07, held until next load ----------------
    pd8 = 8'h07; dv8 = 1'b1;
    tick();
    dv8 = 1'b0; pd8 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      en8 = 1'b1;
      #1;
      check("par_even_07", {31'd0, par_l}, 32'd1);
      check("par_odd_07",  {31'd0, par_m}, 32'd0);
      check("par_07_bit",  {31'd0, sd_l},  {31'd0, word_07[i]});
      tick();
    end
    en8 = 1'b0;
    tick();
    #1;
    check("par_hold_idle", {31'd0, par_l}, 32'd1);
`endif

    // ---------------- 12-bit, ignored mid-word load, back-to-back ----------------
    pd12 = 12'hABC; dv12 = 1'b1;
    tick();
    en12 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin
        dv12 = 1'b1; pd12 = 12'h555;
      end else if (i == 11) begin
        dv12 = 1'b1; pd12 = 12'h123;
      end else begin
        dv12 = 1'b0;
      end
      #1;
      check("w12_abc_bit",   {31'd0, sd_w},   {31'd0, word_abc[i]});
      check("w12_abc_done",  {31'd0, done_w}, (i == 11) ? 32'd1 : 32'd0);
      check("w12_abc_ready", {31'd0, rdy_w},  (i == 11) ? 32'd1 : 32'd0);
      tick();
    end
    dv12 = 1'b0; pd12 = 12'h000;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("w12_123_bit",  {31'd0, sd_w},   {31'd0, word_123[i]});
      check("w12_123_busy", {31'd0, busy_w}, 32'd1);
      check("w12_123_done", {31'd0, done_w}, (i == 11) ? 32'd1 : 32'd0);
      tick();
    end
    en12 = 1'b0;
    #1;
    check("w12_end_busy",  {31'd0, busy_w}, 32'd0);
    check("w12_end_ready", {31'd0, rdy_w},  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
